rpn_stack_engine: RTL and testbench

- Initiator for the 8-bit `stack` instruction interface: drives `instruction`/`data_in` and consumes `data_out`/`empty`/`full`.
- Accepts a token stream over a valid/ready handshake and evaluates it in reverse-Polish notation. Operands become pushes; operators become pop-pop-compute-push sequences; emit becomes a peek that returns the top of stack.
- Sits between a command source (host or test sequencer) and one `stack` instance.

---
 rtl/rpn_stack_engine_if.sv | 33 +++
 rtl/rpn_stack_engine.sv | 212 +++++++++++++++++++++
 tb/tb_rpn_stack_engine.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_engine_if.sv
// -----------------------------------------------------------------------------
// rpn_stack_engine_if
// Token/result channel between a command source and the RPN stack engine.
//   tok_valid    : source -> engine, a token is offered
//   tok_ready    : engine -> source, engine can accept a token this cycle
//   tok_is_op    : source -> engine, 1 = tok_data is an opcode, 0 = operand
//   tok_data     : source -> engine, operand value or opcode
//   result       : engine -> source, value returned by EMIT
//   result_valid : engine -> source, one-cycle pulse qualifying result
//   err          : engine -> source, sticky error flag
// Modports: master = command source, slave = engine.
// -----------------------------------------------------------------------------
interface rpn_stack_engine_if #(
    parameter int DATA_W = 8
);
    logic              tok_valid;
    logic              tok_ready;
    logic              tok_is_op;
    logic [DATA_W-1:0] tok_data;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              err;

    modport master (
        output tok_valid, tok_is_op, tok_data,
        input  tok_ready, result, result_valid, err
    );

    modport slave (
        input  tok_valid, tok_is_op, tok_data,
        output tok_ready, result, result_valid, err
    );
endinterface

// File: rtl/rpn_stack_engine.sv
// -----------------------------------------------------------------------------
// rpn_stack_engine
// Evaluates a reverse-Polish token stream using an external stack block.
// Operands become PUSH, operators become POP/POP/PUSH(f(A,B)), EMIT becomes a
// PEEK whose read data is returned on result with a one-cycle result_valid.
// Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 XOR, 4 EMIT, 5 MUL (optional).
// Build option: define RPN_STACK_ENGINE_MUL_EN to build the multiplier and make
// opcode 5 legal; otherwise opcode 5 is illegal and drives the engine to ERR.
// Ports:
//   clk          : rising-edge clock shared with the stack
//   reset        : synchronous active-low reset
//   tok          : token/result channel (rpn_stack_engine_if.slave)
//   stk_instr    : stack instruction, 00 PUSH, 01 POP, 10 PEEK, 11 NOP
//   stk_data_in  : push data
//   stk_data_out : stack read data (registered inside the stack)
//   stk_empty    : stack empty flag (registered inside the stack)
//   stk_full     : stack full flag (registered inside the stack)
// -----------------------------------------------------------------------------
module rpn_stack_engine #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    rpn_stack_engine_if.slave   tok,
    output logic [1:0]          stk_instr,
    output logic [DATA_W-1:0]   stk_data_in,
    input  logic [DATA_W-1:0]   stk_data_out,
    input  logic                stk_empty,
    input  logic                stk_full
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PUSH   = 3'd1,
        S_POP_B  = 3'd2,
        S_POP_A  = 3'd3,
        S_PUSH_R = 3'd4,
        S_PEEK   = 3'd5,
        S_RESULT = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [1:0] INSTR_PUSH = 2'b00;
    localparam logic [1:0] INSTR_POP  = 2'b01;
    localparam logic [1:0] INSTR_PEEK = 2'b10;
    localparam logic [1:0] INSTR_NOP  = 2'b11;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd5;

    localparam logic [DATA_W-1:0] OPC_EMIT = DATA_W'(4);
    localparam logic [DATA_W-1:0] OPC_MUL  = DATA_W'(5);

    state_t            state_r;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] operand_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] result_r;
    logic              result_valid_r;
    logic              err_r;
    logic              opcode_legal_s;
    logic [DATA_W-1:0] alu_s;

    // Binary operator; A is the deeper stack entry, arithmetic wraps.
    function automatic logic [DATA_W-1:0] alu_f(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_AND:  alu_f = a & b;
            OP_XOR:  alu_f = a ^ b;
`ifdef RPN_STACK_ENGINE_MUL_EN
            OP_MUL:  alu_f = a * b;
`endif
            default: alu_f = '0;
        endcase
    endfunction

    // Opcode legality: EMIT is the highest legal code unless MUL is built.
    always_comb begin
        opcode_legal_s = 1'b0;
`ifdef RPN_STACK_ENGINE_MUL_EN
        opcode_legal_s = (tok.tok_data <= OPC_MUL);
`else
        opcode_legal_s = (tok.tok_data <= OPC_EMIT);
`endif
    end

    // The popped A operand only exists on stk_data_out during PUSH_R, so the
    // computed value is presented combinationally in that state.
    always_comb begin
        alu_s = alu_f(op_r, stk_data_out, b_r);
        if (state_r == S_PUSH_R) begin
            stk_data_in = alu_s;
        end else begin
            stk_data_in = operand_r;
        end
    end

    // Stack instruction decode. Flags only settle after the previous stack
    // operation, so the full/empty guard is applied against the live flags.
    always_comb begin
        stk_instr = INSTR_NOP;
        case (state_r)
            S_PUSH: begin
                if (stk_full) stk_instr = INSTR_NOP;
                else          stk_instr = INSTR_PUSH;
            end
            S_POP_B, S_POP_A: begin
                if (stk_empty) stk_instr = INSTR_NOP;
                else           stk_instr = INSTR_POP;
            end
            S_PEEK: begin
                if (stk_empty) stk_instr = INSTR_NOP;
                else           stk_instr = INSTR_PEEK;
            end
            S_PUSH_R: stk_instr = INSTR_PUSH;
            default:  stk_instr = INSTR_NOP;
        endcase
    end

    assign tok.tok_ready    = (state_r == S_IDLE);
    assign tok.result       = result_r;
    assign tok.result_valid = result_valid_r;
    assign tok.err          = err_r;

    // Token sequencer: accept, walk the stack access sequence, trap errors.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= S_IDLE;
            op_r           <= 3'd0;
            operand_r      <= '0;
            b_r            <= '0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (tok.tok_valid) begin
                        if (!tok.tok_is_op) begin
                            operand_r <= tok.tok_data;
                            state_r   <= S_PUSH;
                        end else if (!opcode_legal_s) begin
                            err_r   <= 1'b1;
                            state_r <= S_ERR;
                        end else if (tok.tok_data == OPC_EMIT) begin
                            state_r <= S_PEEK;
                        end else begin
                            op_r    <= tok.tok_data[2:0];
                            state_r <= S_POP_B;
                        end
                    end
                end
                S_PUSH: begin
                    if (stk_full) begin
                        err_r   <= 1'b1;
                        state_r <= S_ERR;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_POP_B: begin
                    if (stk_empty) begin
                        err_r   <= 1'b1;
                        state_r <= S_ERR;
                    end else begin
                        state_r <= S_POP_A;
                    end
                end
                S_POP_A: begin
                    // B was returned by the POP issued in POP_B.
                    b_r <= stk_data_out;
                    if (stk_empty) begin
                        err_r   <= 1'b1;
                        state_r <= S_ERR;
                    end else begin
                        state_r <= S_PUSH_R;
                    end
                end
                S_PUSH_R: state_r <= S_IDLE;
                S_PEEK: begin
                    if (stk_empty) begin
                        err_r   <= 1'b1;
                        state_r <= S_ERR;
                    end else begin
                        state_r <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    result_r       <= stk_data_out;
                    result_valid_r <= 1'b1;
                    state_r        <= S_IDLE;
                end
                S_ERR: begin
                    err_r   <= 1'b1;
                    state_r <= S_ERR;
                end
                default: begin
                    err_r   <= 1'b1;
                    state_r <= S_ERR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rpn_stack_engine.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_engine
// Directed bench for rpn_stack_engine with a 4-deep stack attached. Expected
// values are hand-computed constants in the vector table and sequences below.
// -----------------------------------------------------------------------------
module tb_rpn_stack_engine;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    stk_instr;
    logic [DW-1:0] stk_data_in;
    logic [DW-1:0] stk_data_out;
    logic          stk_empty;
    logic          stk_full;

    rpn_stack_engine_if #(.DATA_W(DW)) tif ();

    rpn_stack_engine #(.DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .tok          (tif),
        .stk_instr    (stk_instr),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_empty    (stk_empty),
        .stk_full     (stk_full)
    );

    always #5 clk = ~clk;

    // Attached stack: registered data_out and flags, same reset as the engine.
    logic [DW-1:0] mem [DEPTH];
    int            sp;
    always @(posedge clk) begin
        if (!reset) begin
            sp           <= 0;
            stk_empty    <= 1'b1;
            stk_full     <= 1'b0;
            stk_data_out <= '0;
        end else begin
            case (stk_instr)
                2'b00: if (sp < DEPTH) begin
                    mem[sp]   <= stk_data_in;
                    sp        <= sp + 1;
                    stk_empty <= 1'b0;
                    stk_full  <= (sp + 1 == DEPTH);
                end
                2'b01: if (sp > 0) begin
                    stk_data_out <= mem[sp-1];
                    sp           <= sp - 1;
                    stk_empty    <= (sp == 1);
                    stk_full     <= 1'b0;
                end
                2'b10: if (sp > 0) stk_data_out <= mem[sp-1];
                default: ;
            endcase
        end
    end

    // Record every non-NOP stack instruction seen in a cycle.
    int         instr_cnt = 0;
    logic [1:0] trace [$];
    always @(negedge clk) begin
        if (stk_instr != 2'b11) begin
            instr_cnt = instr_cnt + 1;
            trace.push_back(stk_instr);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Offer a token until accepted (bounded); returns right after the accept edge.
    task automatic send(input logic is_op, input logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        tif.tok_valid = 1'b1;
        tif.tok_is_op = is_op;
        tif.tok_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (tif.tok_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        tif.tok_valid = 1'b0;
        tif.tok_data  = 8'hA5;
    endtask

    // Send a token and watch cycles 1.. for result_valid until ready or err.
    task automatic run_tok(input logic is_op, input logic [DW-1:0] d,
                           output bit ok, output bit seen,
                           output logic [DW-1:0] res, output int lat);
        seen = 1'b0;
        res  = '0;
        lat  = 0;
        send(is_op, d, ok);
        if (ok) begin
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (tif.result_valid) begin
                    seen = 1'b1;
                    res  = tif.result;
                    lat  = k;
                end
                if (tif.tok_ready || tif.err) break;
            end
        end
    endtask

    typedef struct {
        bit            rst;
        bit            is_op;
        logic [DW-1:0] d;
        bit            chk;
        logic [DW-1:0] exp;
        bit            exp_err;
    } vec_t;

    vec_t vecs [24];

    initial begin
        bit            ok;
        bit            seen;
        logic [DW-1:0] res;
        int            lat;
        int            start;
        int            cnt0;

        vecs[0]  = '{1'b1, 1'b0, 8'd10,  1'b0, 8'd0,   1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'd20,  1'b0, 8'd0,   1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'd4,   1'b1, 8'd20,  1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'd1,   1'b0, 8'd0,   1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'd4,   1'b1, 8'd246, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'd250, 1'b0, 8'd0,   1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'd10,  1'b0, 8'd0,   1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'd0,   1'b0, 8'd0,   1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'd4,   1'b1, 8'd4,   1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'd3,   1'b0, 8'd0,   1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'd4,   1'b1, 8'd242, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'd15,  1'b0, 8'd0,   1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'd2,   1'b0, 8'd0,   1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'd4,   1'b1, 8'd2,   1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0};
        vecs[15] = '{1'b0, 1'b0, 8'd1,   1'b0, 8'd0,   1'b0};
        vecs[16] = '{1'b0, 1'b1, 8'd1,   1'b0, 8'd0,   1'b0};
        vecs[17] = '{1'b0, 1'b1, 8'd4,   1'b1, 8'd255, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 8'd7,   1'b0, 8'd0,   1'b1};
        vecs[19] = '{1'b1, 1'b0, 8'd3,   1'b0, 8'd0,   1'b0};
        vecs[20] = '{1'b0, 1'b1, 8'd0,   1'b0, 8'd0,   1'b1};
        vecs[21] = '{1'b0, 1'b1, 8'd4,   1'b0, 8'd0,   1'b1};
        vecs[22] = '{1'b1, 1'b1, 8'd4,   1'b0, 8'd0,   1'b1};
        vecs[23] = '{1'b1, 1'b1, 8'd200, 1'b0, 8'd0,   1'b1};

        tif.tok_valid = 1'b0;
        tif.tok_is_op = 1'b0;
        tif.tok_data  = '0;

        // Reset state.
        do_reset();
        check("rst_ready", tif.tok_ready, 1);
        check("rst_instr", stk_instr, 2'b11);
        check("rst_data_in", stk_data_in, 0);
        check("rst_result", tif.result, 0);
        check("rst_result_valid", tif.result_valid, 0);
        check("rst_err", tif.err, 0);

        // Push 10, push 20, EMIT: instruction trace and EMIT latency.
        start = trace.size();
        run_tok(1'b0, 8'd10, ok, seen, res, lat);
        check("p10_accept", ok, 1);
        run_tok(1'b0, 8'd20, ok, seen, res, lat);
        check("p20_accept", ok, 1);
        run_tok(1'b1, 8'd4, ok, seen, res, lat);
        check("emit_seen", seen, 1);
        check("emit_result", res, 20);
        check("emit_latency", lat, 3);
        #1;
        check("trace_len", trace.size() - start, 3);
        if (trace.size() - start == 3) begin
            check("trace0", trace[start], 2'b00);
            check("trace1", trace[start+1], 2'b00);
            check("trace2", trace[start+2], 2'b10);
        end

        // Table-driven token vectors.
        for (int i = 0; i < 24; i++) begin
            if (vecs[i].rst) do_reset();
            if (tif.err) begin
                check($sformatf("v%0d_err_held", i), tif.err, vecs[i].exp_err);
                continue;
            end
            run_tok(vecs[i].is_op, vecs[i].d, ok, seen, res, lat);
            check($sformatf("v%0d_accept", i), ok, 1);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_seen", i), seen, 1);
                check($sformatf("v%0d_result", i), res, vecs[i].exp);
                check($sformatf("v%0d_lat", i), lat, 3);
            end
            check($sformatf("v%0d_err", i), tif.err, vecs[i].exp_err);
        end

        // Operator latency: POP cycles 1 and 2, PUSH cycle 3, ready in cycle 4.
        do_reset();
        run_tok(1'b0, 8'd1, ok, seen, res, lat);
        run_tok(1'b0, 8'd2, ok, seen, res, lat);
        send(1'b1, 8'd0, ok);
        @(negedge clk);
        check("op_c1_instr", stk_instr, 2'b01);
        @(negedge clk);
        check("op_c2_instr", stk_instr, 2'b01);
        @(negedge clk);
        check("op_c3_instr", stk_instr, 2'b00);
        check("op_c3_data", stk_data_in, 3);
        check("op_c3_ready", tif.tok_ready, 0);
        @(negedge clk);
        check("op_c4_ready", tif.tok_ready, 1);

        // Reset during POP_A of an ADD, then push 5, EMIT.
        do_reset();
        run_tok(1'b0, 8'd1, ok, seen, res, lat);
        run_tok(1'b0, 8'd2, ok, seen, res, lat);
        send(1'b1, 8'd0, ok);
        @(negedge clk);
        @(negedge clk);
        check("midrst_popa", stk_instr, 2'b01);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_instr", stk_instr, 2'b11);
        check("midrst_ready", tif.tok_ready, 1);
        check("midrst_err", tif.err, 0);
        reset = 1'b1;
        run_tok(1'b0, 8'd5, ok, seen, res, lat);
        run_tok(1'b1, 8'd4, ok, seen, res, lat);
        check("midrst_emit", res, 5);
        check("midrst_seen", seen, 1);

        // MUL: 7 * 40 = 280 -> 24; without MUL the opcode is illegal.
        do_reset();
        run_tok(1'b0, 8'd7, ok, seen, res, lat);
        run_tok(1'b0, 8'd40, ok, seen, res, lat);
        #1;
        cnt0 = instr_cnt;
`ifdef RPN_STACK_ENGINE_MUL_EN
        run_tok(1'b1, 8'd5, ok, seen, res, lat);
        check("mul_err", tif.err, 0);
        run_tok(1'b1, 8'd4, ok, seen, res, lat);
        check("mul_result", res, 24);
`else
        send(1'b1, 8'd5, ok);
        check("mul_off_accept", ok, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mul_off_err", tif.err, 1);
        check("mul_off_no_instr", instr_cnt - cnt0, 0);
`endif

        // Full stack: a fifth push issues nothing and sets err.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            run_tok(1'b0, 8'(i + 1), ok, seen, res, lat);
        end
        check("full_flag", stk_full, 1);
        #1;
        cnt0 = instr_cnt;
        send(1'b0, 8'd1, ok);
        check("full_accept", ok, 1);
        @(negedge clk);
        check("full_nop", stk_instr, 2'b11);
        @(negedge clk);
        check("full_err", tif.err, 1);
        check("full_ready", tif.tok_ready, 0);

        // Error is sticky: offered tokens are never taken, nothing is issued.
        tif.tok_valid = 1'b1;
        tif.tok_is_op = 1'b0;
        tif.tok_data  = 8'd9;
        for (int k = 0; k < 6; k++) @(negedge clk);
        #1;
        check("sticky_ready", tif.tok_ready, 0);
        check("sticky_err", tif.err, 1);
        check("sticky_no_instr", instr_cnt - cnt0, 0);
        tif.tok_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
